uart_cmd_resp: RTL and testbench

UART_CMD_RESP -- requirements
Module: uart_cmd_resp

---
 rtl/uart_cmd_resp.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_resp.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_resp.sv
// Byte-oriented command/response engine: decodes UART opcodes to drive CPU reset,
// program a base/length window, and stream bytes into or out of a word-wide memory.
module uart_cmd_resp #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            cpu_fault_i,
   input  logic [7:0]      rx_data_i,
   input  logic            rx_data_vld_i,
   output logic            rx_data_rdy_o,
   output logic [7:0]      tx_data_o,
   output logic            tx_data_vld_o,
   input  logic            tx_data_rdy_i,
   output logic [XLEN-1:0] mem_rd_addr_o,
   input  logic [XLEN-1:0] mem_rd_data_i,
   output logic [XLEN-1:0] mem_wr_addr_o,
   output logic [XLEN-1:0] mem_wr_data_o,
   output logic [3:0]      mem_wr_byte_en_o,
   output logic            cpu_rst_n_o
);

   // state        | meaning
   // S_IDLE       | waiting for an opcode byte
   // S_CONF_WR    | collecting base (4 bytes LE) then length field (4 bytes LE)
   // S_DATA_WR    | writing N payload bytes to base+i
   // S_CONF_RD    | transmitting base then length field, 8 bytes
   // S_DATA_RD_A  | read address presented, waiting for memory word
   // S_DATA_RD_TX | loading and transmitting the selected byte lane
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_CONF_WR    = 3'd1;
   localparam logic [2:0] S_DATA_WR    = 3'd2;
   localparam logic [2:0] S_CONF_RD    = 3'd3;
   localparam logic [2:0] S_DATA_RD_A  = 3'd4;
   localparam logic [2:0] S_DATA_RD_TX = 3'd5;

   localparam logic [7:0] OP_CPU_RST = 8'h2A;
   localparam logic [7:0] OP_CPU_RUN = 8'h2B;
   localparam logic [7:0] OP_CONF_WR = 8'h2C;
   localparam logic [7:0] OP_CONF_RD = 8'h2D;
   localparam logic [7:0] OP_DATA_WR = 8'h2E;
   localparam logic [7:0] OP_DATA_RD = 8'h2F;

   logic [2:0]      state_q;
   logic [XLEN-1:0] cnt_q;
   logic [XLEN-1:0] base_q;
   logic [XLEN-1:0] len_q;
   logic [7:0]      tx_data_q;
   logic            tx_vld_q;
   logic [XLEN-1:0] rd_addr_q;
   logic [XLEN-1:0] wr_addr_q;
   logic [XLEN-1:0] wr_data_q;
   logic [3:0]      byte_en_q;
   logic            cpu_rst_n_q;

   logic            rx_fire;
   logic            tx_fire;
   logic [XLEN-1:0] wr_addr_nxt;
   logic [2:0]      cfg_idx;
   logic [7:0]      cfg_byte;
   logic [7:0]      rd_byte;
   logic            last_byte;

   // Gated by rst_n_i so the block never advertises readiness while held in reset.
   assign rx_data_rdy_o = rst_n_i &
                          ((state_q == S_IDLE) || (state_q == S_CONF_WR) || (state_q == S_DATA_WR));

   assign rx_fire     = rx_data_vld_i & rx_data_rdy_o;
   assign tx_fire     = tx_vld_q & tx_data_rdy_i;
   assign wr_addr_nxt = base_q + cnt_q;
   assign last_byte   = (cnt_q == len_q);
   assign cfg_idx     = cnt_q[2:0] + 3'd1;
   assign rd_byte     = mem_rd_data_i[8*rd_addr_q[1:0] +: 8];

   always_comb begin
      cfg_byte = 8'h00;
      if (cfg_idx[2]) cfg_byte = len_q[8*cfg_idx[1:0] +: 8];
      else            cfg_byte = base_q[8*cfg_idx[1:0] +: 8];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         base_q      <= '0;
         len_q       <= '0;
         tx_data_q   <= '0;
         tx_vld_q    <= 1'b0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         byte_en_q   <= '0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         byte_en_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (rx_fire) begin
                  cnt_q <= '0;
                  case (rx_data_i)
                     OP_CPU_RST: cpu_rst_n_q <= 1'b0;
                     OP_CPU_RUN: cpu_rst_n_q <= 1'b1;
                     OP_CONF_WR: state_q <= S_CONF_WR;
                     OP_DATA_WR: state_q <= S_DATA_WR;
                     OP_CONF_RD: begin
                        tx_data_q <= base_q[7:0];
                        tx_vld_q  <= 1'b1;
                        state_q   <= S_CONF_RD;
                     end
                     OP_DATA_RD: begin
                        rd_addr_q <= base_q;
                        state_q   <= S_DATA_RD_A;
                     end
                     default: ;
                  endcase
               end
            end
            S_CONF_WR: begin
               if (rx_fire) begin
                  if (cnt_q[2]) len_q[8*cnt_q[1:0] +: 8]  <= rx_data_i;
                  else          base_q[8*cnt_q[1:0] +: 8] <= rx_data_i;
                  if (cnt_q[2:0] == 3'd7) begin
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_DATA_WR: begin
               if (rx_fire) begin
                  wr_addr_q <= wr_addr_nxt;
                  wr_data_q <= {(XLEN/8){rx_data_i}};
                  byte_en_q <= 4'(4'b0001 << wr_addr_nxt[1:0]);
                  if (last_byte) begin
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_CONF_RD: begin
               if (tx_fire) begin
                  if (cnt_q[2:0] == 3'd7) begin
                     tx_vld_q <= 1'b0;
                     cnt_q    <= '0;
                     state_q  <= S_IDLE;
                  end else begin
                     tx_data_q <= cfg_byte;
                     cnt_q     <= cnt_q + 1'b1;
                  end
               end
            end
            S_DATA_RD_A: state_q <= S_DATA_RD_TX;
            S_DATA_RD_TX: begin
               // First cycle here captures the lane; the byte then stays registered until taken.
               if (!tx_vld_q) begin
                  tx_data_q <= rd_byte;
                  tx_vld_q  <= 1'b1;
               end else if (tx_data_rdy_i) begin
                  tx_vld_q <= 1'b0;
                  if (last_byte) begin
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q     <= cnt_q + 1'b1;
                     rd_addr_q <= rd_addr_q + 1'b1;
                     state_q   <= S_DATA_RD_A;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
         if (cpu_fault_i) cpu_rst_n_q <= 1'b0;
      end
   end

   assign tx_data_o        = tx_data_q;
   assign tx_data_vld_o    = tx_vld_q;
   assign mem_rd_addr_o    = rd_addr_q;
   assign mem_wr_addr_o    = wr_addr_q;
   assign mem_wr_data_o    = wr_data_q;
   assign mem_wr_byte_en_o = byte_en_q;
   assign cpu_rst_n_o      = cpu_rst_n_q;

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Scoreboard bench for uart_cmd_resp: command tasks push expected writes/transmits,
// a negedge monitor pops and compares whenever the DUT presents a write pulse or tx byte.
module tb_uart_cmd_resp;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        cpu_fault_i;
   logic [7:0]  rx_data_i;
   logic        rx_data_vld_i;
   logic        rx_data_rdy_o;
   logic [7:0]  tx_data_o;
   logic        tx_data_vld_o;
   logic        tx_data_rdy_i;
   logic [31:0] mem_rd_addr_o;
   logic [31:0] mem_rd_data_i;
   logic [31:0] mem_wr_addr_o;
   logic [31:0] mem_wr_data_o;
   logic [3:0]  mem_wr_byte_en_o;
   logic        cpu_rst_n_o;

   uart_cmd_resp #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .cpu_fault_i(cpu_fault_i),
      .rx_data_i(rx_data_i), .rx_data_vld_i(rx_data_vld_i), .rx_data_rdy_o(rx_data_rdy_o),
      .tx_data_o(tx_data_o), .tx_data_vld_o(tx_data_vld_o), .tx_data_rdy_i(tx_data_rdy_i),
      .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
      .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
      .mem_wr_byte_en_o(mem_wr_byte_en_o), .cpu_rst_n_o(cpu_rst_n_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [7:0] data; logic chk_addr; logic [31:0] addr; } tx_t;

   wr_t         exp_wr[$];
   tx_t         exp_tx[$];
   logic [7:0]  ref_mem [logic [31:0]];
   logic [31:0] mem_w   [logic [29:0]];
   logic [31:0] m_base = 0;
   logic [31:0] m_len  = 0;
   int          rdy_mode = 0;
   int          checks = 0;
   int          failures = 0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return mem_w.exists(a[31:2]) ? mem_w[a[31:2]] : 32'h0;
   endfunction

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // Memory bus: samples address/strobe at the edge, returns the word one cycle later.
   initial begin
      mem_rd_data_i = 32'h0;
      forever begin
         logic [31:0] ra, wa, wd, w;
         logic [3:0]  be;
         @(posedge clk_i);
         ra = mem_rd_addr_o; wa = mem_wr_addr_o; wd = mem_wr_data_o; be = mem_wr_byte_en_o;
         #1;
         if (rst_n_i && be != 4'h0) begin
            w = word_at(wa);
            for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
            mem_w[wa[31:2]] = w;
         end
         mem_rd_data_i = word_at(ra);
      end
   end

   initial begin
      tx_data_rdy_i = 1'b1;
      forever begin
         @(posedge clk_i); #1;
         case (rdy_mode)
            0: tx_data_rdy_i = 1'b1;
            1: tx_data_rdy_i = ~tx_data_rdy_i;
            default: tx_data_rdy_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor
   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (mem_wr_byte_en_o != 4'h0) begin
            if (exp_wr.size() == 0) begin
               check("unexpected_wr_pulse", {28'h0, mem_wr_byte_en_o}, 64'h0);
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               check("wr_addr", mem_wr_addr_o, e.addr);
               check("wr_be", mem_wr_byte_en_o, 4'b0001 << e.addr[1:0]);
               check("wr_data", mem_wr_data_o, {4{e.data}});
            end
         end
         if (prev_stall) check("tx_hold", {tx_data_vld_o, tx_data_o}, {1'b1, prev_data});
         prev_stall = tx_data_vld_o & ~tx_data_rdy_i;
         prev_data  = tx_data_o;
         if (tx_data_vld_o && tx_data_rdy_i) begin
            if (exp_tx.size() == 0) begin
               check("unexpected_tx", {1'b1, tx_data_o}, 64'h0);
            end else begin
               tx_t t;
               t = exp_tx.pop_front();
               check("tx_data", tx_data_o, t.data);
               if (t.chk_addr) check("rd_addr", mem_rd_addr_o, t.addr);
            end
         end
         if (exp_tx.size() != 0) check("rx_backpressure", rx_data_rdy_o, 1'b0);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data_i = b;
      rx_data_vld_i = 1'b1;
      forever begin
         @(negedge clk_i);
         if (rx_data_rdy_o) break;
         n++;
         if (n > 3000) begin
            check("rx_accept_timeout", 64'h0, 64'h1);
            break;
         end
      end
      @(posedge clk_i); #1;
      rx_data_vld_i = 1'b0;
   endtask

   task automatic conf_wr(input logic [31:0] base, input logic [31:0] len);
      send_byte(8'h2C);
      for (int k = 0; k < 4; k++) send_byte(base[8*k +: 8]);
      for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8]);
      m_base = base;
      m_len  = len;
   endtask

   task automatic data_wr();
      logic [7:0]  b;
      logic [31:0] a;
      send_byte(8'h2E);
      for (int i = 0; i <= int'(m_len); i++) begin
         a = m_base + 32'(i);
         b = ($urandom_range(0, 3) == 0) ? 8'(8'h2A + $urandom_range(0, 5)) : 8'($urandom);
         ref_mem[a] = b;
         exp_wr.push_back('{addr: a, data: b});
         send_byte(b);
      end
   endtask

   task automatic conf_rd();
      logic [63:0] cfg;
      send_byte(8'h2D);
      cfg = {m_len, m_base};
      for (int k = 0; k < 8; k++) exp_tx.push_back('{data: cfg[8*k +: 8], chk_addr: 1'b0, addr: 32'h0});
   endtask

   task automatic data_rd();
      logic [31:0] a;
      send_byte(8'h2F);
      for (int i = 0; i <= int'(m_len); i++) begin
         a = m_base + 32'(i);
         exp_tx.push_back('{data: ref_byte(a), chk_addr: 1'b1, addr: a});
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_wr.size() != 0 || exp_tx.size() != 0) begin
         @(posedge clk_i);
         n++;
         if (n > 3000) begin
            check("drain_timeout", 64'(exp_wr.size() + exp_tx.size()), 64'h0);
            exp_wr.delete();
            exp_tx.delete();
         end
      end
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [7:0] jb;
      rst_n_i = 1'b0; cpu_fault_i = 1'b0; rx_data_i = 8'h00; rx_data_vld_i = 1'b0;
      #12;
      check("rst_rx_rdy", rx_data_rdy_o, 1'b0);
      check("rst_cpu_rst_n", cpu_rst_n_o, 1'b0);
      check("rst_tx_vld", tx_data_vld_o, 1'b0);
      check("rst_be", mem_wr_byte_en_o, 4'h0);
      repeat (2) @(posedge clk_i);
      #1 rst_n_i = 1'b1;
      #1 check("post_rst_rx_rdy", rx_data_rdy_o, 1'b1);

      // 22-byte write from address 0
      send_byte(8'h2A);
      check("cpu_rst_op", cpu_rst_n_o, 1'b0);
      conf_wr(32'h0, 32'd21);
      data_wr();
      drain();
      check("last_wr_addr", mem_wr_addr_o, 32'd21);

      // Config readback with a toggling transmitter ready
      rdy_mode = 1;
      conf_wr(32'h10, 32'd3);
      conf_rd();
      drain();

      // Lane-selected reads
      rdy_mode = 2;
      mem_w[30'h4] = 32'h44332211;
      for (int k = 0; k < 4; k++) ref_mem[32'h10 + 32'(k)] = 8'(8'h11 * (k + 1));
      conf_wr(32'h11, 32'd1);
      data_rd();
      drain();

      // Address wrap
      conf_wr(32'hFFFF_FFFE, 32'd3);
      data_wr();
      drain();
      data_rd();
      drain();

      // CPU reset control and fault override
      send_byte(8'h2B);
      check("cpu_run", cpu_rst_n_o, 1'b1);
      cpu_fault_i = 1'b1;
      @(posedge clk_i); #1;
      check("cpu_fault", cpu_rst_n_o, 1'b0);
      cpu_fault_i = 1'b0;
      send_byte(8'h2B);
      check("cpu_run_again", cpu_rst_n_o, 1'b1);
      cpu_fault_i = 1'b1;
      send_byte(8'h2B);
      check("fault_over_run", cpu_rst_n_o, 1'b0);
      cpu_fault_i = 1'b0;

      // Randomized command mix
      for (int it = 0; it < 40; it++) begin
         rdy_mode = $urandom_range(0, 2);
         case ($urandom_range(0, 6))
            0: conf_wr(($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)),
                       32'($urandom_range(0, 6)));
            1, 2: data_wr();
            3: data_rd();
            4: conf_rd();
            5: begin
               jb = 8'($urandom);
               if (jb >= 8'h2A && jb <= 8'h2F) jb = jb ^ 8'h80;
               send_byte(jb);
            end
            default: begin
               jb = ($urandom_range(0, 1) != 0) ? 8'h2A : 8'h2B;
               send_byte(jb);
               check("cpu_rand", cpu_rst_n_o, jb[0]);
            end
         endcase
      end
      drain();

      // Reset in the middle of a data write
      conf_wr(32'h100, 32'd5);
      send_byte(8'h2E);
      for (int i = 0; i < 2; i++) begin
         jb = 8'($urandom);
         exp_wr.push_back('{addr: 32'h100 + 32'(i), data: jb});
         send_byte(jb);
      end
      @(negedge clk_i); #2;
      rst_n_i = 1'b0;
      #1;
      check("mid_rst_rx_rdy", rx_data_rdy_o, 1'b0);
      check("mid_rst_cpu", cpu_rst_n_o, 1'b0);
      check("mid_rst_tx", {tx_data_vld_o, tx_data_o}, 9'h0);
      check("mid_rst_be", mem_wr_byte_en_o, 4'h0);
      check("mid_rst_addrs", {mem_rd_addr_o, mem_wr_addr_o}, 64'h0);
      check("mid_rst_wdata", mem_wr_data_o, 32'h0);
      m_base = 32'h0;
      m_len  = 32'h0;
      repeat (3) @(posedge clk_i);
      #1 rst_n_i = 1'b1;
      #1 check("rerst_rx_rdy", rx_data_rdy_o, 1'b1);
      conf_rd();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
